// File: rtl/uart_pkg.sv
// Shared UART definitions: line FSM states, default timing constants and frame geometry.
// Imported by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int UART_CLK_FREQ   = 50_000_000;
    localparam int UART_BAUD_RATE  = 115200;
    localparam int UART_FRAME_BITS = 10;
    localparam int UART_DATA_BITS  = 8;

    // Clock cycles per line bit; integer truncation is intentional.
    function automatic int bit_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte handshake between a producer (master) and the UART transmitter buffer (slave).
interface uart_transmitter_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] tx_data;
    logic                      tx_valid;
    logic                      tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the transmitter; head byte is readable without a pop.
// Full/empty come from the occupancy count, pointers wrap naturally (power-of-two depth).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
)
(
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  logic [UART_DATA_BITS-1:0]       push_data,
    input  logic                            pop,
    output logic [UART_DATA_BITS-1:0]       pop_data,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH):0]     count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [UART_DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr_r;
    logic [AW-1:0]             rd_ptr_r;
    logic [CW-1:0]             count_r;
    logic                      push_s;
    logic                      pop_s;

    assign full     = (count_r == CW'(FIFO_DEPTH));
    assign empty    = (count_r == CW'(0));
    assign push_s   = push && !full;
    assign pop_s    = pop && !empty;
    assign pop_data = mem_r[rd_ptr_r];
    assign count    = count_r;

    // Storage array; contents only matter once counted, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a registered-output line FSM.
// Frames run back-to-back while bytes are buffered; TxD idles high.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = UART_CLK_FREQ,
    parameter int BAUD_RATE  = UART_BAUD_RATE,
    parameter int FIFO_DEPTH = 4
)
(
    input  logic                        clk,
    input  logic                        reset,
    uart_transmitter_if.slave           tx_if,
    output logic                        TxD,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int                BIT_DIV   = bit_div(CLK_FREQ, BAUD_RATE);
    localparam int                BW        = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [BW-1:0]     BAUD_LAST = BW'(BIT_DIV - 1);

    uart_state_e               state_r;
    logic [BW-1:0]             baud_cnt_r;
    logic [2:0]                bit_cnt_r;
    logic [UART_DATA_BITS-1:0] shift_r;
    logic                      txd_r;
    logic                      busy_r;

    logic                      bit_end_s;
    logic                      pop_s;
    logic                      fifo_full_s;
    logic                      fifo_empty_s;
    logic [UART_DATA_BITS-1:0] fifo_data_s;

    uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_if.tx_valid),
        .push_data (tx_if.tx_data),
        .pop       (pop_s),
        .pop_data  (fifo_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count)
    );

    assign tx_if.tx_ready = !fifo_full_s;
    assign bit_end_s      = (baud_cnt_r == BAUD_LAST);
    assign TxD            = txd_r;
    assign tx_busy        = busy_r;

    // Head byte leaves the FIFO on the cycle a frame is launched.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            IDLE:    pop_s = !fifo_empty_s;
            STOP:    pop_s = bit_end_s && !fifo_empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Line FSM with baud/bit counters; TxD and tx_busy are registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            baud_cnt_r <= BW'(0);
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            txd_r      <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    baud_cnt_r <= BW'(0);
                    bit_cnt_r  <= 3'd0;
                    if (!fifo_empty_s) begin
                        state_r <= START;
                        shift_r <= fifo_data_s;
                        txd_r   <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        txd_r  <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        state_r    <= DATA;
                        baud_cnt_r <= BW'(0);
                        txd_r      <= shift_r[0];
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BW'(1);
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= BW'(0);
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= STOP;
                            txd_r   <= 1'b1;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            shift_r   <= shift_r >> 1;
                            txd_r     <= shift_r[1];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BW'(1);
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= BW'(0);
                        bit_cnt_r  <= 3'd0;
                        if (!fifo_empty_s) begin
                            state_r <= START;
                            shift_r <= fifo_data_s;
                            txd_r   <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                            txd_r   <= 1'b1;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BW'(1);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    baud_cnt_r <= BW'(0);
                    bit_cnt_r  <= 3'd0;
                    txd_r      <= 1'b1;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a queue-based line model predicts TxD/tx_busy/tx_ready/fifo_count
// every cycle; a serial decoder on TxD plus directed scenarios pin the model with literal values.
module tb_uart_transmitter;

    localparam int TB_CLK  = 1_000_000;
    localparam int TB_BAUD = 77_000;
    localparam int DEPTH   = 4;
    localparam int BD      = TB_CLK / TB_BAUD;
    localparam int FRAME   = 10 * BD;

    logic       clk;
    logic       reset;
    logic       TxD;
    logic       tx_busy;
    logic [2:0] fifo_count;

    int n_cmp = 0;
    int n_err = 0;

    uart_transmitter_if ifc ();

    uart_transmitter #(
        .CLK_FREQ   (TB_CLK),
        .BAUD_RATE  (TB_BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_if      (ifc),
        .TxD        (TxD),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: buffered bytes plus the per-cycle waveform still owed on the line.
    logic [7:0] mq[$];
    logic       lq[$];
    logic       exp_txd  = 1'b1;
    logic       exp_busy = 1'b0;

    initial begin
        logic       do_push;
        logic [7:0] pd;
        logic [7:0] b;
        logic       bitv;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mq.delete();
                lq.delete();
                exp_txd  = 1'b1;
                exp_busy = 1'b0;
            end else begin
                do_push = ifc.tx_valid && (mq.size() < DEPTH);
                pd      = ifc.tx_data;
                if (lq.size() == 0 && mq.size() != 0) begin
                    b = mq.pop_front();
                    for (int k = 0; k < 10; k++) begin
                        bitv = (k == 0) ? 1'b0 : ((k == 9) ? 1'b1 : b[k-1]);
                        for (int c = 0; c < BD; c++) lq.push_back(bitv);
                    end
                end
                if (do_push) mq.push_back(pd);
                if (lq.size() != 0) begin
                    exp_txd  = lq.pop_front();
                    exp_busy = 1'b1;
                end else begin
                    exp_txd  = 1'b1;
                    exp_busy = 1'b0;
                end
            end
        end
    end

    // Per-cycle compare of every output against the model.
    initial begin
        logic       exp_ready;
        logic [2:0] exp_cnt;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_ready = (mq.size() < DEPTH);
                exp_cnt   = 3'(mq.size());
                n_cmp++;
                if ({TxD, tx_busy, ifc.tx_ready, fifo_count} !== {exp_txd, exp_busy, exp_ready, exp_cnt}) begin
                    n_err++;
                    $display("FAIL line_state t=%0t: got txd=%b busy=%b ready=%b count=%0d, expected txd=%b busy=%b ready=%b count=%0d",
                             $time, TxD, tx_busy, ifc.tx_ready, fifo_count, exp_txd, exp_busy, exp_ready, exp_cnt);
                end
            end
        end
    end

    // Serial decoder on TxD, samples mid-bit; a reset during a frame discards it.
    logic [7:0] rx_q[$];
    logic       rx_abort = 1'b0;

    initial forever begin
        @(posedge reset);
        rx_abort = 1'b1;
    end

    initial begin
        logic [7:0] rb;
        forever begin
            @(negedge clk);
            if (!reset && TxD === 1'b0) begin
                rx_abort = 1'b0;
                repeat (BD / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    rb[i] = TxD;
                end
                repeat (BD) @(negedge clk);
                if (TxD === 1'b1 && !rx_abort) rx_q.push_back(rb);
            end
        end
    end

    // Busy statistics for gap detection.
    int   busy_cyc   = 0;
    int   busy_rises = 0;
    logic busy_prev  = 1'b0;

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (tx_busy) busy_cyc++;
            if (tx_busy && !busy_prev) busy_rises++;
            busy_prev = tx_busy;
        end else begin
            busy_prev = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s t=%0t: timed out waiting", name, $time);
    endtask

    task automatic push(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!ifc.tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.tx_ready) timeout_fail("push_ready");
        ifc.tx_data  = b;
        ifc.tx_valid = 1'b1;
        @(negedge clk);
        ifc.tx_valid = 1'b0;
    endtask

    task automatic wait_txd_low(input int limit, output int waited);
        waited = 0;
        while (TxD !== 1'b0 && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        if (TxD !== 1'b0) timeout_fail("wait_start_bit");
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((tx_busy || fifo_count != 3'd0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (tx_busy || fifo_count != 3'd0) timeout_fail("wait_drain");
        repeat (4) @(negedge clk);
    endtask

    task automatic check_rx(input string name, input logic [7:0] exp_b[$]);
        check({name, "_nbytes"}, 32'(rx_q.size()), 32'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++)
            check(name, 32'(rx_q[i]), 32'(exp_b[i]));
    endtask

    initial begin
        int         w;
        int         cnt;
        logic [9:0] seq;
        logic [7:0] acc_q[$];
        logic [7:0] exp_b[$];
        int         thr;

        reset        = 1'b1;
        ifc.tx_valid = 1'b0;
        ifc.tx_data  = 8'h00;
        #1;
        check("reset_txd",   32'(TxD), 32'd1);
        check("reset_busy",  32'(tx_busy), 32'd0);
        check("reset_ready", 32'(ifc.tx_ready), 32'd1);
        check("reset_count", 32'(fifo_count), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Single 0x55 frame: one-cycle launch latency, 120-cycle busy, alternating bits.
        push(8'h55);
        wait_txd_low(10, w);
        check("launch_latency", 32'(w), 32'd1);
        cnt = 0;
        seq = 10'h000;
        while (tx_busy && cnt < 200) begin
            if (cnt % BD == BD / 2) seq[cnt / BD] = TxD;
            cnt++;
            @(negedge clk);
        end
        check("frame_len", 32'(cnt), 32'd120);
        check("frame_bits", 32'(seq), 32'(10'b10_1010_1010));
        repeat (4) @(negedge clk);
        exp_b = '{8'h55};
        check_rx("rx_55", exp_b);

        // Four back-to-back frames with no idle gap.
        rx_q.delete();
        busy_cyc   = 0;
        busy_rises = 0;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        wait_drain(1000);
        check("b2b_busy_cycles", 32'(busy_cyc), 32'd480);
        check("b2b_busy_rises", 32'(busy_rises), 32'd1);
        exp_b = '{8'h01, 8'h02, 8'h03, 8'h04};
        check_rx("rx_b2b", exp_b);

        // Overflow: six offered while busy, only four fit.
        rx_q.delete();
        push(8'hEE);
        for (int i = 0; i < 6; i++) begin
            ifc.tx_data  = 8'h10 + 8'(i);
            ifc.tx_valid = 1'b1;
            @(negedge clk);
        end
        ifc.tx_valid = 1'b0;
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_ready", 32'(ifc.tx_ready), 32'd0);
        wait_drain(1500);
        exp_b = '{8'hEE, 8'h10, 8'h11, 8'h12, 8'h13};
        check_rx("rx_full", exp_b);

        // Push coinciding with the stop-bit pop while two bytes are buffered.
        rx_q.delete();
        push(8'hA1);
        push(8'hB2);
        push(8'hC3);
        check("pre_pushpop_count", 32'(fifo_count), 32'd2);
        cnt = 0;
        while (!(lq.size() == 0 && tx_busy) && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        if (!(lq.size() == 0 && tx_busy)) timeout_fail("wait_stop_end");
        ifc.tx_data  = 8'hD4;
        ifc.tx_valid = 1'b1;
        @(negedge clk);
        ifc.tx_valid = 1'b0;
        check("pushpop_count", 32'(fifo_count), 32'd2);
        check("pushpop_txd", 32'(TxD), 32'd0);
        wait_drain(1000);
        exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        check_rx("rx_pushpop", exp_b);

        // Reset in the middle of data bit 3 aborts the frame and flushes the buffer.
        rx_q.delete();
        push(8'hA5);
        push(8'h77);
        wait_txd_low(20, w);
        repeat (4 * BD + BD / 2 - 2) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_txd",   32'(TxD), 32'd1);
        check("midreset_busy",  32'(tx_busy), 32'd0);
        check("midreset_ready", 32'(ifc.tx_ready), 32'd1);
        check("midreset_count", 32'(fifo_count), 32'd0);
        repeat (3) @(negedge clk);
        reset      = 1'b0;
        busy_cyc   = 0;
        busy_rises = 0;
        repeat (300) @(negedge clk);
        check("postreset_rises", 32'(busy_rises), 32'd0);
        check("postreset_rx", 32'(rx_q.size()), 32'd0);

        // Randomized traffic with varying offered load.
        rx_q.delete();
        acc_q.delete();
        for (int seg = 0; seg < 4; seg++) begin
            thr = (seg == 0) ? 2 : ((seg == 1) ? 60 : ((seg == 2) ? 8 : 150));
            for (int c = 0; c < 800; c++) begin
                ifc.tx_valid = ($urandom_range(thr - 1, 0) == 0);
                ifc.tx_data  = 8'($urandom);
                if (ifc.tx_valid && ifc.tx_ready) acc_q.push_back(ifc.tx_data);
                @(negedge clk);
            end
        end
        ifc.tx_valid = 1'b0;
        wait_drain(4000);
        check_rx("rx_random", acc_q);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 Parameter FIFO_DEPTH, default 4, power of two, ≥2; transmit buffer entries.
REQ-004 clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 tx_data  input  8  byte to send; sampled when tx_valid && tx_ready.
REQ-007 tx_valid  input  1  producer offers tx_data this cycle.
REQ-008 tx_ready  output  1  buffer can accept a byte; high iff FIFO not full.
REQ-009 TxD  output  1  serial line; idle high; feeds the receiver RxD.
REQ-010 tx_busy  output  1  high while a frame is on the line (any state other than IDLE).
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered, excluding the byte in flight.

Function
REQ-012 BIT_DIV = CLK_FREQ/BAUD_RATE (integer truncation; 434 at defaults); each line bit lasts exactly BIT_DIV clk cycles.
REQ-013 Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity; 10*BIT_DIV cycles per frame.
REQ-014 FSM states IDLE, START, DATA, STOP; IDLE->START when FIFO non-empty; START->DATA after BIT_DIV cycles; DATA->STOP after 8th bit; STOP->START if FIFO non-empty at end of stop bit, else IDLE.
REQ-015 On IDLE->START the head byte is popped into an internal shift register in the same cycle; TxD goes low on the next cycle (1-cycle latency from FIFO non-empty in IDLE to start bit).
REQ-016 Back-to-back frames: no idle gap between a stop bit and the next start bit when the FIFO is non-empty.
REQ-017 Push occurs on tx_valid && tx_ready; tx_data held in FIFO unchanged until popped.
REQ-018 Simultaneous push and pop: both occur; fifo_count unchanged.
REQ-019 FIFO full: tx_ready low; tx_valid ignored, no overwrite, count stays FIFO_DEPTH.
REQ-020 FIFO empty: no pop; FSM remains/returns IDLE, TxD high.
REQ-021 Read/write pointers wrap modulo FIFO_DEPTH; full/empty derived from fifo_count.
REQ-022 Baud counter counts 0..BIT_DIV-1, restarts at 0 on every state change and every bit boundary.
REQ-023 TxD registered (no combinational path from inputs to TxD).

Reset
REQ-024 On reset assertion, immediately: TxD=1, tx_busy=0, tx_ready=1, fifo_count=0, FSM=IDLE, baud and bit counters=0, pointers=0.
REQ-025 Reset mid-frame aborts the frame; buffered bytes are discarded; no partial frame resumes after release.
REQ-026 First start bit after reset release occurs no earlier than the second cycle after the first accepted push.

Structure
REQ-027 Shared package uart_pkg holds the state enum (IDLE/START/DATA/STOP), default CLK_FREQ/BAUD_RATE constants and the frame-length constant (10 bits), shared with the receiver.
REQ-028 One sub-module uart_tx_fifo (synchronous FIFO, parameter FIFO_DEPTH, 8-bit data, count output) instantiated once; FSM and baud counter stay in uart_transmitter.

Verification
REQ-029 Push 0x55 once -> TxD: 0,1,0,1,0,1,0,1,0,1 each held 434 cycles, then high; tx_busy high for exactly 4340 cycles.
REQ-030 Push 0x01,0x02,0x03,0x04 back-to-back -> four contiguous 4340-cycle frames, no idle gap, tx_busy never drops between them.
REQ-031 Hold tx_valid high with 6 bytes while line busy -> tx_ready low once fifo_count=4; extra bytes not accepted; sent bytes match accepted order.
REQ-032 Push 0xA5, assert reset during data bit 3 -> TxD high same cycle, fifo_count=0, no further frame after release.
REQ-033 Loopback TxD->RxD of receiver at defaults, send 0xA5 then 0x3C -> RxData 0xA5 then 0x3C, valid_rx one-cycle pulse per frame.
REQ-034 Push and pop in same cycle with fifo_count=2 -> fifo_count stays 2.
